// File: rtl/mux_rr_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_stream
// Brief    : N:1 valid/ready stream multiplexer with a registered output.
//            The channel is chosen by a fixed select or by round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // One extra bit so that ptr + offset never overflows before the wrap.
  localparam logic [SEL_W:0] c_chans = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;

  logic             w_slot_free;
  logic             w_gnt_any;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W:0]   w_scan;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;
  logic [SEL_W-1:0] w_ptr_next;

  assign w_slot_free = !r_valid || out_ready;
  assign w_xfer      = w_gnt_any && w_slot_free;
  assign w_ptr_next  = (w_gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : w_gnt_idx + 1'b1;

  // Grant selection: the fixed select only matches real channel indices, so an
  // out-of-range sel simply yields no grant; round-robin takes the first valid
  // channel at or after ptr, wrapping modulo CHANNELS.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        w_scan = {1'b0, r_ptr} + (SEL_W+1)'(k);
        if (w_scan >= c_chans) begin
          w_scan = w_scan - c_chans;
        end
        if (!w_gnt_any && in_valid[w_scan[SEL_W-1:0]]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_scan[SEL_W-1:0];
        end
      end
    end
  end

  // Data of the granted channel, captured into the output register on transfer.
  always_comb begin
    w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];
  end

  // Ready is one-hot on the granted channel and forced low while in reset.
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ready
      assign in_ready[i] = rst_n && w_slot_free && w_gnt_any &&
                           (w_gnt_idx == SEL_W'(i));
    end
  endgenerate

  // Output register and round-robin pointer; a push in the same cycle as a pop
  // replaces the beat, otherwise a pop empties the slot and data is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= w_gnt_data;
      r_chan  <= w_gnt_idx;
      r_valid <= 1'b1;
      if (mode) begin
        r_ptr <= w_ptr_next;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_stream
// Brief    : Self-checking bench for mux_rr_stream (16- and 5-channel builds)
//            against a behavioural stream-mux reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_stream;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [3:0]   sel;
  logic [127:0] in_data;
  logic [15:0]  in_valid;
  logic [15:0]  in_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  logic         mode5;
  logic [2:0]   sel5;
  logic [39:0]  in_data5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic [7:0]   out_data5;
  logic [2:0]   out_chan5;
  logic         out_valid5;
  logic         out_ready5;

  int checks   = 0;
  int failures = 0;

  // reference model state for the 16-channel instance
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;

  mux_rr_stream #(.WIDTH(8), .CHANNELS(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_rr_stream #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which channel the arbiter should pick, or -1 for none.
  function automatic int mgrant(input bit md, input int s, input logic [15:0] v, input int p);
    if (!md) return (s < 16 && v[s]) ? s : -1;
    for (int k = 0; k < 16; k++) begin
      int c;
      c = (p + k) % 16;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_ready();
    int g;
    g = mgrant(mode, int'(sel), in_valid, m_ptr);
    if (g >= 0 && (!m_valid || out_ready) && rst_n) return 16'(1) << g;
    return 16'h0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // Advance one clock edge and apply the transfer rules to the model.
  task automatic tick();
    int g;
    bit free;
    @(posedge clk);
    g    = mgrant(mode, int'(sel), in_valid, m_ptr);
    free = !m_valid || out_ready;
    if (g >= 0 && free) begin
      m_data  = in_data[g*8 +: 8];
      m_chan  = g;
      m_valid = 1'b1;
      if (mode) m_ptr = (g + 1) % 16;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    mode = 1'b0; sel = 4'd5; in_valid = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(i + 16);
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(i + 32);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++;
    if (out_chan !== 4'd0) begin failures++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
    checks++;
    if (in_ready !== 16'h0) begin failures++; $display("FAIL reset_in_ready got=%h exp=0000", in_ready); end
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 4'd5; in_valid = 16'hFFFF; out_ready = 1'b1;
    checks++;
    if (in_ready !== 16'h0020) begin failures++; $display("FAIL fixed_in_ready got=%h exp=0020", in_ready); end
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h15 || out_chan !== 4'd5) begin
        failures++;
        $display("FAIL fixed_out cyc=%0d got v=%b d=%h c=%0d exp v=1 d=15 c=5", n, out_valid, out_data, out_chan);
      end
      checks++;
      if (in_ready !== 16'h0020) begin failures++; $display("FAIL fixed_in_ready_rep got=%h exp=0020", in_ready); end
    end
  endtask

  task automatic test_rr_all();
    mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin failures++; $display("FAIL rr_in_ready got=%h exp=%h", in_ready, exp_ready()); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_chan) != k % 16 || out_data !== 8'(k % 16 + 16)) begin
        failures++;
        $display("FAIL rr_seq k=%0d got v=%b c=%0d d=%h exp c=%0d", k, out_valid, out_chan, out_data, k % 16);
      end
    end
  endtask

  task automatic test_sparse();
    mode = 1'b1; in_valid = 16'h8101; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      tick();
      checks++;
      if (out_valid !== m_valid || int'(out_chan) != m_chan || out_data !== m_data) begin
        failures++;
        $display("FAIL sparse k=%0d got v=%b c=%0d d=%h exp v=%b c=%0d d=%h", k, out_valid, out_chan, out_data, m_valid, m_chan, m_data);
      end
      checks++;
      if (out_chan !== 4'd0 && out_chan !== 4'd8 && out_chan !== 4'd15) begin
        failures++; $display("FAIL sparse_set got=%0d exp=0/8/15", out_chan);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 4'd3; in_valid = 16'h0008; out_ready = 1'b1;
    in_data[3*8 +: 8] = 8'hA3;
    #1;
    checks++;
    if (in_ready !== 16'h0008) begin failures++; $display("FAIL bp_accept_ready got=%h exp=0008", in_ready); end
    tick();
    out_ready = 1'b0;
    in_data[3*8 +: 8] = 8'hB3;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++;
      if (in_ready !== 16'h0) begin failures++; $display("FAIL bp_stall_ready cyc=%0d got=%h exp=0000", n, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA3 || out_chan !== 4'd3) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h c=%0d exp v=1 d=a3 c=3", n, out_valid, out_data, out_chan);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 16'h0008) begin failures++; $display("FAIL bp_release_ready got=%h exp=0008", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB3 || out_chan !== 4'd3) begin
      failures++;
      $display("FAIL bp_replace got v=%b d=%h c=%0d exp v=1 d=b3 c=3", out_valid, out_data, out_chan);
    end
    in_data[3*8 +: 8] = 8'h13;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; model_reset();
    #2 rst_n = 1'b1;
    mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 4'd6) begin
      failures++; $display("FAIL mid_pre got v=%b c=%0d exp v=1 c=6", out_valid, out_chan);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_chan !== 4'd0 || out_data !== 8'h00 || in_ready !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset got v=%b c=%0d d=%h r=%h exp all zero", out_valid, out_chan, out_data, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_hold_reset got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    #1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 4'd0 || out_data !== 8'h10) begin
      failures++; $display("FAIL mid_first_grant got v=%b c=%0d d=%h exp v=1 c=0 d=10", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      mode      = 1'($urandom);
      sel       = 4'($urandom);
      in_valid  = 16'($urandom) & 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < 4; w++) in_data[w*32 +: 32] = $urandom;
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_in_ready n=%0d got=%h exp=%h", n, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || int'(out_chan) != m_chan) begin
        failures++;
        $display("FAIL rand_out n=%0d got v=%b d=%h c=%0d exp v=%b d=%h c=%0d", n, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
  endtask

  task automatic test_nonpow2();
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (in_ready5 !== 5'h0) begin failures++; $display("FAIL np2_sel_ready got=%h exp=00", in_ready5); end
      tick();
      checks++;
      if (out_valid5 !== 1'b0) begin failures++; $display("FAIL np2_sel_valid got=%b exp=0", out_valid5); end
    end
    mode5 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1;
      tick();
      checks++;
      if (out_valid5 !== 1'b1 || int'(out_chan5) != k % 5 || out_data5 !== 8'(k % 5 + 32)) begin
        failures++;
        $display("FAIL np2_rr k=%0d got v=%b c=%0d d=%h exp c=%0d", k, out_valid5, out_chan5, out_data5, k % 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_all();
    test_sparse();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_nonpow2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
